// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch with credit-limited request/grant fetch and in-order fetch queue
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_out,
    output logic [31:0] if_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] inflight, discard, count;
    logic [CW:0]   used;
    logic [PW-1:0] fp_wr, fp_rd, q_hd, q_tl;
    logic [31:0]   fpc   [DEPTH];
    logic [31:0]   q_pc  [DEPTH];
    logic [31:0]   q_ins [DEPTH];
    logic          grant, rv, push, pop;
    logic          unused_low_bits;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit uses registered counts only, so id_ready/imem_rvalid never reach imem_req
    assign used            = {1'b0, inflight} + {1'b0, count};
    assign imem_req        = rst_n && !redirect && (used < (CW+1)'(DEPTH));
    assign imem_addr       = pc;
    assign grant           = imem_req && imem_gnt;
    assign rv              = imem_rvalid && (inflight != '0);
    assign push            = rv && !redirect && (discard == '0);
    assign if_valid        = count != '0;
    assign pop             = if_valid && id_ready && !redirect;
    assign if_out          = if_valid ? q_ins[q_hd] : NOP;
    assign if_pc           = if_valid ? q_pc[q_hd] : 32'h0;
    assign unused_low_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            fp_wr    <= '0;
            fp_rd    <= '0;
            q_hd     <= '0;
            q_tl     <= '0;
        end else begin
            if (grant) fp_wr <= nxt(fp_wr);
            if (rv) fp_rd <= nxt(fp_rd);
            inflight <= inflight + CW'(grant) - CW'(rv);
            if (redirect) begin
                // every response still outstanding after this cycle belongs to the old path
                pc      <= {redirect_pc[31:2], 2'b00};
                discard <= inflight - CW'(rv);
                count   <= '0;
                q_hd    <= q_tl;
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (rv && discard != '0) discard <= discard - CW'(1);
                if (push) q_tl <= nxt(q_tl);
                if (pop) q_hd <= nxt(q_hd);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) fpc[fp_wr] <= pc;
        if (push) begin
            q_pc[q_tl]  <= fpc[fp_rd];
            q_ins[q_tl] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a sequential-fetch stream model
module tb_if_stage;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 0, rst_n = 0;
    logic        imem_gnt = 0, imem_rvalid = 0, redirect = 0, id_ready = 0;
    logic [31:0] imem_rdata = 0, redirect_pc = 0;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_out, if_pc;

    if_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_out(if_out), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] mq_addr[$];
    int          mq_rdy[$];
    bit          mq_stale[$];
    logic [31:0] fetch_pc, exp_pc, redir_target;
    int          buffered, grants, pops;
    int          gnt_pct, rdy_pct, rv_pct, lat_min, lat_max;
    bit          do_redir;

    task automatic clear_model();
        mq_addr.delete(); mq_rdy.delete(); mq_stale.delete();
        fetch_pc = 32'h0; exp_pc = 32'h0; buffered = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 0; imem_gnt = 0; imem_rvalid = 0; redirect = 0; id_ready = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    // one clock: drive inputs, observe outputs mid-cycle, then advance the memory/stream model
    task automatic cycle();
        bit exp_req, p, st;
        @(negedge clk);
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        id_ready    = ($urandom_range(99) < rdy_pct);
        redirect    = do_redir;
        redirect_pc = redir_target;
        do_redir    = 0;
        imem_rvalid = 0;
        imem_rdata  = $urandom;
        if (mq_addr.size() > 0 && mq_rdy[0] <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1;
            imem_rdata  = mq_addr[0] ^ KEY;
        end
        #1;
        exp_req = !redirect && (mq_addr.size() + buffered < DEPTH);
        checks++;
        if (imem_req !== exp_req) begin
            failures++;
            $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
        end
        if (imem_req) begin
            checks++;
            if (imem_addr !== fetch_pc) begin
                failures++;
                $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr, fetch_pc);
            end
        end
        if (!if_valid) begin
            checks++;
            if (if_out !== NOP || if_pc !== 32'h0) begin
                failures++;
                $display("FAIL idle_out cyc=%0d got out=%h pc=%h exp out=%h pc=0", cyc, if_out, if_pc, NOP);
            end
        end
        p = if_valid && id_ready && !redirect;
        if (p) begin
            checks++;
            if (if_pc !== exp_pc || if_out !== (exp_pc ^ KEY)) begin
                failures++;
                $display("FAIL deliver cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h", cyc, if_pc, if_out, exp_pc, exp_pc ^ KEY);
            end
            exp_pc += 32'd4;
            pops++;
            buffered--;
        end
        if (imem_rvalid) begin
            void'(mq_addr.pop_front()); void'(mq_rdy.pop_front());
            st = mq_stale.pop_front();
            if (!st && !redirect) buffered++;
        end
        if (redirect) begin
            foreach (mq_stale[i]) mq_stale[i] = 1;
            buffered = 0;
            fetch_pc = {redir_target[31:2], 2'b00};
            exp_pc   = fetch_pc;
        end else if (imem_req && imem_gnt) begin
            mq_addr.push_back(fetch_pc);
            mq_rdy.push_back(cyc + lat_min + $urandom_range(lat_max));
            mq_stale.push_back(0);
            fetch_pc += 32'd4;
            grants++;
        end
        cyc++;
    endtask

    task automatic knobs(input int g, input int r, input int v, input int lmin, input int lmax);
        gnt_pct = g; rdy_pct = r; rv_pct = v; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_out !== NOP || if_pc !== 32'h0) begin
            failures++;
            $display("FAIL %s got req=%b addr=%h v=%b out=%h pc=%h exp req=0 addr=0 v=0 out=%h pc=0",
                     tag, imem_req, imem_addr, if_valid, if_out, if_pc, NOP);
        end
    endtask

    task automatic wait_first_valid(input string tag, input logic [31:0] want);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (if_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout got no if_valid exp pc=%h", tag, want);
        end else if (if_pc !== want) begin
            failures++;
            $display("FAIL %s got pc=%h exp=%h", tag, if_pc, want);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #2 rst_n = 0;
        #1 check_reset_outputs("reset_hold");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_hold2");
        clear_model();
        @(posedge clk); #2 rst_n = 1;
        knobs(0, 0, 100, 1, 0);
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_release got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_streaming();
        logic ev;
        do_reset();
        knobs(100, 100, 100, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            ev = (i >= 2);
            checks++;
            if (if_valid !== ev) begin
                failures++;
                $display("FAIL stream_valid i=%0d got=%b exp=%b", i, if_valid, ev);
            end
            if (i >= 2) begin
                checks++;
                if (if_pc !== 32'(4 * (i - 2)) || if_out !== (32'(4 * (i - 2)) ^ KEY)) begin
                    failures++;
                    $display("FAIL stream_pc i=%0d got pc=%h ins=%h exp pc=%h", i, if_pc, if_out, 32'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure_and_stall();
        int g0, p0;
        do_reset();
        knobs(100, 0, 100, 1, 0);
        g0 = grants;
        repeat (10) cycle();
        checks++;
        if (grants - g0 != 4 || imem_req !== 1'b0 || if_pc !== 32'h0 || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure got grants=%0d req=%b pc=%h v=%b exp grants=4 req=0 pc=0 v=1",
                     grants - g0, imem_req, if_pc, if_valid);
        end
        knobs(0, 100, 100, 1, 0);
        p0 = pops;
        repeat (8) cycle();
        checks++;
        if (pops - p0 != 4 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got pops=%0d v=%b exp pops=4 v=0", pops - p0, if_valid);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                failures++;
                $display("FAIL gnt_stall i=%0d got req=%b addr=%h exp req=1 addr=10", i, imem_req, imem_addr);
            end
        end
        knobs(100, 100, 100, 1, 0);
        cycle();
        knobs(0, 100, 100, 1, 0);
        cycle();
        checks++;
        if (imem_addr !== 32'h14) begin
            failures++;
            $display("FAIL gnt_advance got addr=%h exp=14", imem_addr);
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        knobs(100, 100, 100, 3, 0);
        cycle(); cycle();
        do_redir = 1; redir_target = 32'h103;
        cycle();
        knobs(100, 100, 100, 1, 0);
        cycle();
        checks++;
        if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_next got addr=%h v=%b exp addr=100 v=0", imem_addr, if_valid);
        end
        wait_first_valid("redir_first", 32'h100);
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        knobs(100, 100, 100, 1, 0);
        cycle();
        do_redir = 1; redir_target = 32'h200;
        cycle();
        cycle();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL coincident got v=%b addr=%h exp v=0 addr=200", if_valid, imem_addr);
        end
        wait_first_valid("coincident_first", 32'h200);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < 4) begin
                do_redir     = 1;
                redir_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF5 : $urandom;
            end
            cycle();
        end
    endtask

    task automatic test_async_reset();
        knobs(80, 60, 70, 1, 3);
        run_random(40);
        #2 rst_n = 0;
        imem_rvalid = 0; redirect = 0; imem_gnt = 0;
        #1 check_reset_outputs("async_reset");
        clear_model();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic test_random();
        knobs(70, 60, 70, 1, 4);
        run_random(800);
        knobs(100, 100, 100, 1, 0);
        run_random(300);
        knobs(40, 90, 50, 2, 6);
        run_random(800);
        knobs(0, 100, 100, 1, 0);
        repeat (40) cycle();
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL random_drain got v=%b req=%b exp v=0 req=1", if_valid, imem_req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_redir = 0; redir_target = 0; grants = 0; pops = 0;
        clear_model();
        test_reset();
        test_streaming();
        test_backpressure_and_stall();
        test_redirect_inflight();
        test_redirect_coincident();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
